finv_arbiter: RTL and testbench
===============================

# finv_arbiter

Round-robin arbiter and sequencer that shares one table-based reciprocal mantissa core among `NREQ` FPU requesters. It accepts single-precision operands over a valid/ready handshake and drives the 23-bit mantissa into the shared core. It carries sign, exponent, requester ID and special-case flags alongside the core's fixed latency, then assembles the IEEE-754 single-precision reciprocal and returns it to the originating requester. It sits between the FPU issue lanes and the reciprocal core instance.

## Interface
- `NREQ`, 2: number of requesters, legal range 2..4.
- `LAT`, 2: core latency in cycles from `core_x` presented to matching `core_y` valid, legal range ≥1.
- `clk` input 1: clock, all state on rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous; drops all in-flight operations.
- `req_valid` input NREQ: per-requester operand valid.
- `req_data` input 32*NREQ: operand of requester i in bits [32i+31:32i].
- `req_ready` output NREQ: one-hot grant (or zero); the handshake completes when valid&ready.
- `core_x` output 23: mantissa to the shared core.
- `core_y` input 23: core result mantissa, LAT cycles after `core_x`.
- `rsp_valid` output NREQ: one-cycle pulse per result, no backpressure.
- `rsp_data` output 32*NREQ: result, same slicing as `req_data`.
- `inflight` output 3: count of accepted, not yet returned operations.

## Operation
- Arbitration is combinational within a cycle. Search `req_valid` starting at pointer `ptr` and going upward, wrapping modulo NREQ. The first set bit is granted. `req_ready` is the one-hot grant.
- `req_ready` = 0 for all requesters while `flush`=1.
- On an accepted request, `ptr` ← granted+1 mod NREQ. With no grant, `ptr` holds.
- At most one acceptance per cycle.
- `core_x` = granted operand's bits [22:0] in the grant cycle, else 23'h0.
- Tag pipeline: LAT+1 stages, each holding {valid, id, sign, res_exp[7:0], mzero, special[1:0]}.
- Operand decode, with e = bits[30:23] and m = bits[22:0]:
  - e==0: special=INF. Result is {s, 8'hFF, 23'h0}; denormals are treated as zero.
  - e==255: special=ZERO. Result is {s, 31'h0}.
  - e≥253 and m≠0, or e≥254 and m==0: special=ZERO, from underflow.
  - m==0, otherwise: exp = 254−e, mantissa 0; `core_y` is ignored.
  - Otherwise: exp = 253−e, mantissa = `core_y`.
- Exponent arithmetic is 9-bit unsigned, and the range is checked before truncation to 8 bits.
- Assembly: at stage LAT, `core_y` is merged with the tag. The result is registered into the output register of requester `id`. `rsp_valid[id]` pulses high for one cycle.
- `inflight` is incremented on acceptance and decremented on `rsp_valid` emission. Both in the same cycle leave it unchanged. Its maximum is LAT+1.
- `flush`: clears every tag valid bit and `inflight` at the next edge. No `rsp_valid` is emitted for dropped operations, including one whose response would assert in the same cycle. `ptr` is unchanged.

## Timing
- Reset (`rstn`=0, asynchronous) gives:
  - `ptr`=0, all tag valids 0, `inflight`=0.
  - `rsp_valid`=0 and `rsp_data`=0 for all requesters.
  - `core_x`=0 and `req_ready`=0. These are combinational and are forced to 0 while in reset.
- Reset mid-operation discards all in-flight work. No stale response appears after release.
- Latency: a request accepted in cycle T has `core_x` valid in T. `core_y` is sampled in T+LAT. `rsp_valid` is high in cycle T+LAT+1.
- Throughput: one result per cycle sustained. Back-to-back grants produce responses on consecutive cycles, in acceptance order.
- Simultaneous requests from all requesters are served in rotating order. Each requester gets its next grant within NREQ cycles of its previous grant.
- A requester holding `req_valid` with unchanged data across a non-grant cycle is legal. Data is sampled only at acceptance.

## Test plan
- Reset and single op (NREQ=2, LAT=2): req0 = 0x40000000 (2.0) accepted at T → `rsp_valid[0]` at T+3 with 0x3F000000. Also 0x3F800000 → 0x3F800000.
- Core path: req1 = 0x40400000 (3.0); bench core model returns 0x2AAAAB → `rsp_data[1]` = 0x3EAAAAAB at T+3. Check that `core_x` = 0x400000 in cycle T.
- Specials:
  - 0x00000000 → 0x7F800000.
  - 0x80000001 → 0xFF800000.
  - 0x7F800000 → 0x00000000.
  - 0xFF000000 (e=254, m=0) → 0x80000000.
  - 0x7E800001 (e=253) → 0x00000000.
- Contention: both requesters hold valid for 6 cycles → grants alternate 0,1,0,1,0,1. Responses arrive on 6 consecutive cycles to the matching ID. `inflight` peaks at 3.
- Flush: accept 2 ops, assert `flush` in the cycle before the first response → no `rsp_valid`, `inflight`=0, `req_ready`=0 during the flush cycle.
- Async reset mid-stream: drop `rstn` between edges with 3 ops in flight → outputs clear immediately. After release, no responses appear and `ptr`=0 (req0 wins a tie).

Source files
------------

// File: rtl/finv_arbiter.sv
// finv_arbiter: round-robin sharing of one reciprocal mantissa core among NREQ FPU requesters,
// tagging each operand alongside the core latency and assembling the IEEE-754 reciprocal.
module finv_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [22:0]          core_x,
    input  logic [22:0]          core_y,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [32*NREQ-1:0]   rsp_data,
    output logic [2:0]           inflight
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = IW + 12;
    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_INF  = 2'd1;
    localparam logic [1:0] SP_ZERO = 2'd2;

    logic [IW-1:0]   ptr, gid, oid;
    logic            found, acc, os, omz;
    logic [31:0]     op, res;
    logic [8:0]      exp9;
    logic [7:0]      oe;
    logic [1:0]      sp, osp;
    logic [TW-1:0]   tag_in;
    logic [TW-1:0]   tg [LAT];
    logic [LAT-1:0]  tv;
    logic [NREQ-1:0] rv;

    // Scanning downward lets the lowest offset from ptr overwrite the others.
    always_comb begin
        gid = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                gid = IW'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
    end

    assign acc       = found & rstn & ~flush;
    assign req_ready = acc ? (NREQ'(1) << gid) : '0;
    assign op        = req_data[32*gid +: 32];
    assign core_x    = acc ? op[22:0] : '0;

    // A borrow or zero result means the reciprocal underflows to zero.
    assign exp9   = ((op[22:0] == 23'h0) ? 9'd254 : 9'd253) - {1'b0, op[30:23]};
    assign sp     = (op[30:23] == 8'h00) ? SP_INF :
                    (op[30:23] == 8'hFF || exp9[8] || exp9 == 9'd0) ? SP_ZERO : SP_NONE;
    assign tag_in = {gid, op[31], exp9[7:0], op[22:0] == 23'h0, sp};

    assign {oid, os, oe, omz, osp} = tg[LAT-1];
    assign res = (osp == SP_INF)  ? {os, 8'hFF, 23'h0} :
                 (osp == SP_ZERO) ? {os, 31'h0} :
                 {os, oe, omz ? 23'h0 : core_y};
    assign rsp_valid = rv & ~{NREQ{flush}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr      <= '0;
            tv       <= '0;
            rv       <= '0;
            rsp_data <= '0;
            inflight <= '0;
            for (int k = 0; k < LAT; k++) tg[k] <= '0;
        end else begin
            if (acc) ptr <= (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
            tv[0] <= acc;
            tg[0] <= tag_in;
            for (int k = 1; k < LAT; k++) begin
                tv[k] <= tv[k-1] & ~flush;
                tg[k] <= tg[k-1];
            end
            rv <= '0;
            if (tv[LAT-1] && !flush) begin
                rv[oid] <= 1'b1;
                rsp_data[32*oid +: 32] <= res;
            end
            inflight <= flush ? 3'd0 : inflight + 3'(acc) - 3'(|rsp_valid);
        end
    end
endmodule

// File: tb/tb_finv_arbiter.sv
// tb_finv_arbiter: directed checks of arbitration, decode, latency, flush and async reset.
module tb_finv_arbiter;
    localparam int NREQ = 2;
    localparam int LAT  = 2;

    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [22:0] core_x, core_y;
    logic [22:0] xs0 = '0, xs1 = '0;
    logic [63:0] rsp_data;
    logic [2:0]  inflight;
    int checks = 0, errors = 0;
    int ifl [10] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0};

    finv_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .core_x(core_x), .core_y(core_y),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Core model: two-cycle delay line with a fixed mantissa function.
    always @(posedge clk) begin
        xs0 <= core_x;
        xs1 <= xs0;
    end
    assign core_y = (xs1 == 23'h400000) ? 23'h2AAAAB : ~xs1;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input int id, input logic [31:0] d, input logic [31:0] e);
        req_valid = 2'b01 << id;
        req_data[32*id +: 32] = d;
        #1;
        chk("grant", req_ready, 2'b01 << id);
        chk("core_x", core_x, d[22:0]);
        cyc;
        req_valid = '0;
        #1;
        chk("inflight_one", inflight, 1);
        cyc;
        #1;
        chk("early_rsp", rsp_valid, 0);
        cyc;
        #1;
        chk("rsp_valid", rsp_valid, 2'b01 << id);
        chk("rsp_data", rsp_data[32*id +: 32], e);
        cyc;
        #1;
        chk("rsp_pulse", rsp_valid, 0);
        chk("inflight_drain", inflight, 0);
        cyc;
    endtask

    initial begin
        req_valid = 2'b11;
        req_data = {32'h40400000, 32'h40000000};
        #3;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_core_x", core_x, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        req_valid = '0;

        run_one(0, 32'h40000000, 32'h3F000000);
        run_one(0, 32'h3F800000, 32'h3F800000);
        run_one(1, 32'h40400000, 32'h3EAAAAAB);
        run_one(0, 32'h00000000, 32'h7F800000);
        run_one(1, 32'h80000001, 32'hFF800000);
        run_one(0, 32'h7F800000, 32'h00000000);
        run_one(0, 32'hFF000000, 32'h80000000);
        run_one(1, 32'h7E800001, 32'h00000000);

        // Contention: ptr is 0 after the last grant went to requester 1.
        req_data = {32'h40400000, 32'h40000000};
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 6) ? 2'b11 : 2'b00;
            #1;
            if (c < 6) begin
                chk("rr_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_core_x", core_x, (c % 2 == 0) ? 23'h0 : 23'h400000);
            end
            chk("rr_rsp_valid", rsp_valid,
                (c >= 3 && c < 9) ? (((c - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            if (c >= 3 && c < 9)
                chk("rr_rsp_data", rsp_data[32*((c - 3) % 2) +: 32],
                    ((c - 3) % 2 == 0) ? 32'h3F000000 : 32'h3EAAAAAB);
            chk("rr_inflight", inflight, ifl[c]);
            cyc;
        end

        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 3) ? 2'b11 : 2'b00;
            flush = (c == 2);
            #1;
            if (c < 2) chk("fl_grant", req_ready, (c == 0) ? 2'b01 : 2'b10);
            if (c == 2) begin
                chk("fl_ready", req_ready, 0);
                chk("fl_core_x", core_x, 0);
                chk("fl_inflight_pre", inflight, 2);
            end
            if (c >= 3) chk("fl_inflight", inflight, 0);
            chk("fl_rsp_valid", rsp_valid, 0);
            cyc;
        end
        flush = 1'b0;

        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b11;
            #1;
            chk("ar_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            cyc;
        end
        req_valid = '0;
        #1;
        chk("ar_inflight_pre", inflight, 3);
        chk("ar_rsp_pre", rsp_valid, 2'b01);
        #1;
        rstn = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_rsp_data", rsp_data, 0);
        chk("ar_inflight", inflight, 0);
        chk("ar_ready", req_ready, 0);
        chk("ar_core_x", core_x, 0);
        cyc;
        cyc;
        rstn = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("ar_no_stale", rsp_valid, 0);
            cyc;
        end
        req_valid = 2'b11;
        #1;
        chk("ar_ptr_tie", req_ready, 2'b01);
        cyc;
        req_valid = '0;
        cyc;
        cyc;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
